// File: rtl/half_adder_carry_resolver.sv
// Iterative carry resolver sitting behind an N-bit half-adder array.
// Each pass feeds the array's sum back as x and its shifted carry back as y
// until no carry remains, then presents {cout, sum} = a + b together with
// the number of passes used. Valid/ready handshake on input and output.
module half_adder_carry_resolver #(
    parameter int N = 4,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  sum,
    output logic          cout,
    output logic [CW-1:0] iters,
    output logic          busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_x;
    logic [N-1:0]  r_y;
    logic          r_cout_acc;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic [CW-1:0] r_iters;
    logic          r_out_valid;

    logic [N-1:0]  w_x_next;
    logic [N-1:0]  w_y_next;
    logic          w_msb_carry;

    // One half-adder pass: sum bits, carries moved up one place (MSB carry
    // leaves y and is folded into the carry-out accumulator instead).
    always_comb begin
        w_x_next    = r_x ^ r_y;
        w_y_next    = (r_x & r_y) << 1;
        w_msb_carry = r_x[N-1] & r_y[N-1];
    end

    // Control FSM and datapath registers; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_cout_acc  <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_iters     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_x        <= a;
                        r_y        <= b;
                        r_cout_acc <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_y == '0) begin
                        r_sum       <= r_x;
                        r_cout      <= r_cout_acc;
                        r_iters     <= r_cnt;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_x        <= w_x_next;
                        r_y        <= w_y_next;
                        // At most one carry ever leaves the MSB, so OR is exact.
                        r_cout_acc <= r_cout_acc | w_msb_carry;
                        r_cnt      <= r_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    // No same-cycle accept of new operands: always pass via IDLE.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !rst;
        busy      = (r_state == ST_RUN);
        out_valid = r_out_valid;
        sum       = r_sum;
        cout      = r_cout;
        iters     = r_iters;
    end

endmodule

// File: tb/tb_half_adder_carry_resolver.sv
// Self-checking bench for half_adder_carry_resolver (N=4).
module tb_half_adder_carry_resolver;

    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic [CW-1:0] iters;
    logic          busy;

    int errors = 0;
    int checks = 0;

    half_adder_carry_resolver #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .iters     (iters),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       cout;
        int         iters;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: sum/cout by plain addition; pass count by resolving carries
    // with integer arithmetic until none are left.
    function automatic void model(input int ai, input int bi,
                                  output int s, output int c, output int k);
        int x;
        int y;
        int t;
        s = (ai + bi) % 16;
        c = (ai + bi) / 16;
        x = ai;
        y = bi;
        k = 0;
        while (y != 0) begin
            t = (x ^ y);
            y = ((x & y) * 2) % 16;
            x = t;
            k++;
        end
    endfunction

    // Internal pass counter must never exceed N.
    always @(negedge clk) begin
        if (dut.r_cnt > CW'(N)) begin
            errors++;
            checks++;
            $display("FAIL cnt_bound: got %0d expected <= %0d", dut.r_cnt, N);
        end
    end

    // Offer operands, wait for the result, stall, then complete the handshake.
    task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_, input int stall,
                           output int got_sum, output int got_cout,
                           output int got_iters, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        a        = ta;
        b        = tb_;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat <= 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        got_sum   = int'(sum);
        got_cout  = int'(cout);
        got_iters = int'(iters);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_sum_stable", int'(sum), got_sum);
            check("stall_valid_held", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drops_after_accept", int'(out_valid), 0);
    endtask

    initial begin
        int s, c, k, lat, es, ec, ek;

        vecs[0] = '{a: 4'b0000, b: 4'b0000, sum: 4'b0000, cout: 1'b0, iters: 0};
        vecs[1] = '{a: 4'b0101, b: 4'b0011, sum: 4'b1000, cout: 1'b0, iters: 4};
        vecs[2] = '{a: 4'b1111, b: 4'b0001, sum: 4'b0000, cout: 1'b1, iters: 4};
        vecs[3] = '{a: 4'b1111, b: 4'b1111, sum: 4'b1110, cout: 1'b1, iters: 2};
        vecs[4] = '{a: 4'b1001, b: 4'b0000, sum: 4'b1001, cout: 1'b0, iters: 0};
        vecs[5] = '{a: 4'b0011, b: 4'b0011, sum: 4'b0110, cout: 1'b0, iters: 2};
        vecs[6] = '{a: 4'b1000, b: 4'b1000, sum: 4'b0000, cout: 1'b1, iters: 1};
        vecs[7] = '{a: 4'b0111, b: 4'b0001, sum: 4'b1000, cout: 1'b0, iters: 4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready_low", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum", int'(sum), 0);
        check("rst_cout", int'(cout), 0);
        check("rst_iters", int'(iters), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", int'(in_ready), 1);

        // Directed vectors with latency check
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].a, vecs[i].b, i % 3, s, c, k, lat);
            check($sformatf("vec%0d_sum", i), s, int'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), c, int'(vecs[i].cout));
            check($sformatf("vec%0d_iters", i), k, vecs[i].iters);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].iters + 1);
        end

        // Backpressure with pending operands on the input side
        in_valid = 1'b1;
        a = 4'b0111;
        b = 4'b0001;
        @(negedge clk);
        a = 4'b0011;
        b = 4'b0011;
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_sum", int'(sum), 8);
            check("bp_cout", int'(cout), 0);
            check("bp_iters", int'(iters), 4);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", int'(out_valid), 0);
        check("bp_idle_in_ready", int'(in_ready), 1);
        check("bp_idle_busy", int'(busy), 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_accept_busy", int'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp_new_sum", int'(sum), 6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN
        in_valid = 1'b1;
        a = 4'b1111;
        b = 4'b0001;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_run_busy", int'(busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_sum", int'(sum), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_idle", int'(in_ready), 1);
        check("mid_rst_no_result", int'(out_valid), 0);
        run_txn(4'b0010, 4'b0010, 0, s, c, k, lat);
        check("post_rst_sum", s, 4);
        check("post_rst_cout", c, 0);

        // All operand pairs with random output stalls
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                run_txn(4'(ia), 4'(ib), int'($urandom_range(0, 3)), s, c, k, lat);
                model(ia, ib, es, ec, ek);
                check($sformatf("ex_%0d_%0d_sum", ia, ib), s, es);
                check($sformatf("ex_%0d_%0d_cout", ia, ib), c, ec);
                check($sformatf("ex_%0d_%0d_iters", ia, ib), k, ek);
                check($sformatf("ex_%0d_%0d_iters_le_n", ia, ib), int'(k <= N), 1);
                check($sformatf("ex_%0d_%0d_latency", ia, ib), lat, ek + 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
